// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - fetch PC owner with next-PC selection and a decode-facing fetch queue
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic [XLEN-1:0]             icache_addr,
    output logic                        icache_req,
    input  logic [31:0]                 icache_data,
    input  logic                        icache_valid,
    output logic [XLEN-1:0]             bp_pc,
    input  logic                        bp_predict_taken,
    input  logic [XLEN-1:0]             bp_predict_target,
    input  logic                        ex_redirect,
    input  logic [XLEN-1:0]             ex_redirect_pc,
    input  logic                        dec_ready,
    output logic                        dec_valid,
    output logic [XLEN-1:0]             dec_pc,
    output logic [31:0]                 dec_inst,
    output logic                        dec_pred_taken,
    output logic [XLEN-1:0]             dec_npc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc_d    [FQ_DEPTH];
    logic [31:0]     fq_inst_q  [FQ_DEPTH];
    logic [31:0]     fq_inst_d  [FQ_DEPTH];
    logic            fq_taken_q [FQ_DEPTH];
    logic            fq_taken_d [FQ_DEPTH];
    logic [XLEN-1:0] fq_npc_q   [FQ_DEPTH];
    logic [XLEN-1:0] fq_npc_d   [FQ_DEPTH];

    logic            full;
    logic            dequeue;
    logic            accept;
    logic [XLEN-1:0] npc;

    assign full        = (count_q == CW'(FQ_DEPTH));
    assign dec_valid   = (count_q != '0);
    assign dequeue     = dec_valid & dec_ready;
    // A full queue may still fetch when decode drains the head in the same cycle.
    assign icache_req  = !full | dequeue;
    assign accept      = icache_req & icache_valid & !ex_redirect;
    assign npc         = bp_predict_taken ? bp_predict_target : pc_q + XLEN'(4);

    assign icache_addr    = pc_q;
    assign bp_pc          = pc_q;
    assign fq_count       = count_q;
    assign dec_pc         = fq_pc_q[head_q];
    assign dec_inst       = fq_inst_q[head_q];
    assign dec_pred_taken = fq_taken_q[head_q];
    assign dec_npc        = fq_npc_q[head_q];

    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fq_pc_d    = fq_pc_q;
        fq_inst_d  = fq_inst_q;
        fq_taken_d = fq_taken_q;
        fq_npc_d   = fq_npc_q;

        if (ex_redirect) begin
            // Flush: the queue empties by snapping head onto tail.
            pc_d    = ex_redirect_pc;
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (accept) begin
                fq_pc_d[tail_q]    = pc_q;
                fq_inst_d[tail_q]  = icache_data;
                fq_taken_d[tail_q] = bp_predict_taken;
                fq_npc_d[tail_q]   = npc;
                tail_d             = tail_q + PW'(1);
                pc_d               = npc;
            end
            if (dequeue) begin
                head_d = head_q + PW'(1);
            end
            case ({accept, dequeue})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_pc_q[i]    <= '0;
                fq_inst_q[i]  <= '0;
                fq_taken_q[i] <= 1'b0;
                fq_npc_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fq_pc_q    <= fq_pc_d;
            fq_inst_q  <= fq_inst_d;
            fq_taken_q <= fq_taken_d;
            fq_npc_q   <= fq_npc_d;
        end
    end
endmodule
